// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - FIFO read-side bundle between a synchronous FIFO and its drain stage
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;

  modport master (
    output fifo_rd_en,
    input  fifo_dout,
    input  fifo_empty
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_dout,
    output fifo_empty
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO drain stage serializing each popped word onto an async serial line
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_PAR   = 3'd5;
  localparam logic [2:0] S_STOP  = 3'd6;

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  par_bit;
  logic                  fetch;
  logic                  bit_end;

  assign fetch      = enable && !fifo.fifo_empty;
  assign bit_end    = (cnt == CNT_LAST);
  assign shift_next = shift_reg >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      par_bit         <= 1'b0;
      tx              <= 1'b1;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      fifo.fifo_rd_en <= 1'b0;
    end else begin
      frame_done      <= 1'b0;
      fifo.fifo_rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fetch) begin
            state           <= S_READ;
            fifo.fifo_rd_en <= 1'b1;
            busy            <= 1'b1;
          end
        end
        S_READ: state <= S_WAIT;
        // Registered FIFO read: the popped word is only valid in this cycle
        S_WAIT: begin
          shift_reg <= fifo.fifo_dout;
          par_bit   <= (PARITY == 2) ? ~(^fifo.fifo_dout) : ^fifo.fifo_dout;
          tx        <= 1'b0;
          cnt       <= '0;
          state     <= S_START;
        end
        S_START: begin
          if (bit_end) begin
            cnt   <= '0;
            tx    <= shift_reg[0];
            state <= S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt       <= '0;
            shift_reg <= shift_next;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= S_PAR;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift_next[0];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PAR: begin
          if (bit_end) begin
            cnt   <= '0;
            tx    <= 1'b1;
            state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Stop exit doubles as the fetch decision so back-to-back frames keep busy high
        S_STOP: begin
          if (bit_end) begin
            cnt        <= '0;
            frame_done <= 1'b1;
            if (fetch) begin
              state           <= S_READ;
              fifo.fifo_rd_en <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
